// File: rtl/uart_pkg.sv
// Shared types and constants for the UART-to-I2C bridge serial paths.
// Holds the transmitter state encoding, the host command bytes and the baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [7:0] CMD_START   = 8'h53;
    localparam logic [7:0] CMD_STOP    = 8'h50;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_GPIO_RD = 8'h49;
    localparam logic [7:0] CMD_GPIO_WR = 8'h4F;
    localparam logic [7:0] CMD_PWR_DN  = 8'h5A;

    // Clocks per serial bit; truncates, so the real rate is never slower than requested.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_resp_tx_if.sv
// Byte push interface into the host-bound UART transmitter.
// The response producer is the master; the transmitter FIFO is the slave.
interface uart_resp_tx_if;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO shared by the UART TX and RX paths.
// Push when full and pop when empty are ignored; DEPTH must be a power of two.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == DEPTH_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_resp_tx.sv
// Host-bound UART transmitter: FIFO-buffered response bytes sent 8N1, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop.
module uart_resp_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_resp_tx_if.slave                 wr,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_resp_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
    end

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_d;
    logic          bit_end;

    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr.wr_valid),
        .pop   (fifo_pop),
        .din   (wr.wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr.wr_ready = !fifo_full;
    assign busy        = (state_q != IDLE);
    assign bit_end     = (baud_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    par_d    = ^fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next frame so back-to-back bytes leave no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        par_d    = ^fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        // tx is registered from the next-state view so the line moves on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx       <= tx_d;
            overflow <= overflow | (wr.wr_valid && fifo_full);
        end
    end

endmodule
